// File: rtl/syscall_responder.sv
// syscall_responder: services the decoder's show/halt syscalls.
// It keeps the display latch and the halt/resume FSM, and conditions the raw
// board "go" button: 2-flop synchronizer, debounce, then rising-edge detect.
module syscall_responder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             show_i,
    input  logic             halt_i,
    input  logic [31:0]      a0_i,
    input  logic             adv_i,
    input  logic             go_btn_i,
    output logic             stall_o,
    output logic             go_o,
    output logic             halted_o,
    output logic [31:0]      disp_o,
    output logic [CNT_W-1:0] show_cnt_o,
    output logic [CNT_W-1:0] halt_cnt_o
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              btn_meta;
    logic              btn_s;
    logic [DB_W-1:0]   db_cnt;
    logic              go_clean;
    logic              go_clean_d;
    logic              go_rise;

    logic              show_acc;
    logic              halt_acc;

    logic [31:0]       disp;
    logic [CNT_W-1:0]  show_cnt;
    logic [CNT_W-1:0]  halt_cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= go_btn_i;
            btn_s    <= btn_meta;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            go_clean   <= 1'b0;
            go_clean_d <= 1'b0;
        end else begin
            go_clean_d <= go_clean;
            if (btn_s == go_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                go_clean <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Only the press (clean 0->1) resumes; release and held levels do nothing.
    assign go_rise = go_clean & ~go_clean_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and request acceptance; requests are only honoured in RUN.
    always_comb begin
        state_nxt = state;
        show_acc  = 1'b0;
        halt_acc  = 1'b0;
        case (state)
            RUN: begin
                show_acc = show_i & adv_i;
                halt_acc = halt_i & adv_i;
                if (halt_acc) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (go_rise) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // The held syscall is the one being released, so halt_i is ignored here.
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Display latch and event counters (counters wrap naturally).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp     <= '0;
            show_cnt <= '0;
            halt_cnt <= '0;
        end else begin
            if (show_acc) begin
                disp     <= a0_i;
                show_cnt <= show_cnt + CNT_W'(1);
            end
            if (halt_acc) begin
                halt_cnt <= halt_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_o    = (state == HALT);
    assign halted_o   = (state == HALT);
    assign go_o       = (state == RELEASE);
    assign disp_o     = disp;
    assign show_cnt_o = show_cnt;
    assign halt_cnt_o = halt_cnt;

endmodule

// File: tb/tb_syscall_responder.sv
// Bench for syscall_responder: directed scenarios plus random traffic, checked
// every cycle against a behavioural model and pinned by literal expectations.
module tb_syscall_responder;

    localparam int DB    = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             show_i;
    logic             halt_i;
    logic [31:0]      a0_i;
    logic             adv_i;
    logic             go_btn_i;
    logic             stall_o;
    logic             go_o;
    logic             halted_o;
    logic [31:0]      disp_o;
    logic [CNT_W-1:0] show_cnt_o;
    logic [CNT_W-1:0] halt_cnt_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    syscall_responder #(.DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .show_i     (show_i),
        .halt_i     (halt_i),
        .a0_i       (a0_i),
        .adv_i      (adv_i),
        .go_btn_i   (go_btn_i),
        .stall_o    (stall_o),
        .go_o       (go_o),
        .halted_o   (halted_o),
        .disp_o     (disp_o),
        .show_cnt_o (show_cnt_o),
        .halt_cnt_o (halt_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: halted/releasing flags, button seen through a 2-cycle
    // delay, accepted once it has disagreed with the clean level for DB edges.
    bit               m_sync1, m_bs, m_clean, m_clean_d, m_rise;
    int               m_run;
    bit               m_halted, m_rel;
    logic [31:0]      m_disp;
    logic [CNT_W-1:0] m_show, m_hcnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sync1 = 0; m_bs = 0; m_clean = 0; m_clean_d = 0; m_run = 0;
            m_halted = 0; m_rel = 0; m_disp = 0; m_show = 0; m_hcnt = 0;
        end else begin
            m_rise = m_clean && !m_clean_d;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_halted) begin
                if (m_rise) begin
                    m_halted = 0;
                    m_rel    = 1;
                end
            end else begin
                if (show_i && adv_i) begin
                    m_disp = a0_i;
                    m_show = m_show + 1'b1;
                end
                if (halt_i && adv_i) begin
                    m_halted = 1;
                    m_hcnt   = m_hcnt + 1'b1;
                end
            end
            m_clean_d = m_clean;
            if (m_bs != m_clean) begin
                m_run++;
                if (m_run == DB) begin
                    m_clean = m_bs;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_bs    = m_sync1;
            m_sync1 = go_btn_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",    {31'd0, stall_o},  {31'd0, m_halted});
            check("halted",   {31'd0, halted_o}, {31'd0, m_halted});
            check("go",       {31'd0, go_o},     {31'd0, m_rel});
            check("disp",     disp_o,            m_disp);
            check("show_cnt", 32'(show_cnt_o),   32'(m_show));
            check("halt_cnt", 32'(halt_cnt_o),   32'(m_hcnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_halt();
        halt_i = 1'b1; adv_i = 1'b1;
        tick(1);
        halt_i = 1'b0; adv_i = 1'b0;
    endtask

    // Press the button, wait (bounded) for the go pulse, then release and let it settle.
    task automatic resume(output int edges);
        go_btn_i = 1'b1;
        edges = 0;
        while (!go_o && edges < 40) begin
            tick(1);
            edges++;
        end
        if (!go_o) begin
            checks++; errors++;
            $display("FAIL resume_timeout: got no go pulse after %0d edges, required within 40", edges);
        end
        go_btn_i = 1'b0;
        tick(DB + 4);
    endtask

    int n, pulses, first_go;

    initial begin
        rst_n = 1'b0; show_i = 0; halt_i = 0; a0_i = 0; adv_i = 0; go_btn_i = 0;

        // 1. reset
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_go", {31'd0, go_o}, 32'd0);
        check("rst_disp", disp_o, 32'd0);
        check("rst_cnts", {16'd0, show_cnt_o, halt_cnt_o}, 32'd0);

        // 2. show, then show without advance
        show_i = 1; adv_i = 1; a0_i = 32'h0000_00AB;
        tick(1);
        check("show_disp", disp_o, 32'hAB);
        check("show_cnt1", 32'(show_cnt_o), 32'd1);
        adv_i = 0; a0_i = 32'h55;
        tick(1);
        show_i = 0;
        check("show_noadv_disp", disp_o, 32'hAB);
        check("show_noadv_cnt", 32'(show_cnt_o), 32'd1);

        // 3. halt and clean resume
        do_halt();
        check("halt_stall", {31'd0, stall_o}, 32'd1);
        check("halt_cnt1", 32'(halt_cnt_o), 32'd1);
        resume(n);
        check("go_latency", n, 32'd7);

        // 4. bounced press while halted
        do_halt();
        go_btn_i = 1; tick(2);
        go_btn_i = 0; tick(2);
        go_btn_i = 1;
        pulses = 0; first_go = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (go_o) begin
                pulses++;
                if (first_go == 0) first_go = i;
            end
        end
        check("bounce_first_go", first_go, 32'd7);
        check("bounce_pulses", pulses, 32'd1);

        // 5. button still held: new halt must stay halted
        do_halt();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (go_o) pulses++;
        end
        check("held_no_pulse", pulses, 32'd0);
        check("held_still_halted", {31'd0, halted_o}, 32'd1);
        go_btn_i = 0;
        tick(DB + 4);
        resume(n);
        check("fresh_press_latency", n, 32'd7);

        // 6a. reset during HALT
        do_halt();
        rst_n = 0;
        tick(1);
        rst_n = 1;
        check("rst_halt_stall", {31'd0, stall_o}, 32'd0);
        check("rst_halt_cnt", 32'(halt_cnt_o), 32'd0);

        // 6b. show and halt together
        show_i = 1; halt_i = 1; adv_i = 1; a0_i = 32'h1234_5678;
        tick(1);
        show_i = 0; halt_i = 0; adv_i = 0;
        check("both_disp", disp_o, 32'h1234_5678);
        check("both_halted", {31'd0, halted_o}, 32'd1);
        resume(n);

        // 6c. halt counter wrap
        for (int i = 1; i < (1 << CNT_W) - 1; i++) begin
            do_halt();
            resume(n);
        end
        check("halt_cnt_max", 32'(halt_cnt_o), 32'hFF);
        do_halt();
        check("halt_cnt_wrap", 32'(halt_cnt_o), 32'd0);
        resume(n);

        // 7. random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            show_i = ($urandom_range(0, 3) == 0);
            halt_i = ($urandom_range(0, 7) == 0);
            adv_i  = ($urandom_range(0, 3) != 0);
            a0_i   = $urandom;
            if ($urandom_range(0, 9) == 0) go_btn_i = ~go_btn_i;
            tick(1);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
